// File: rtl/pixel_unpacker_if.sv
// Scanout bus between the framebuffer FIFO / HDMI core (master) and the pixel unpacker (slave).
// Carries the FWFT FIFO head, pixel requests, colour configuration and the unpacked pixel output.
interface pixel_unpacker_if #(
   parameter int WORD_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   logic [WORD_WIDTH-1:0] i_word;
   logic                  i_empty;
   logic                  o_rd_en;
   logic                  i_pixel_ready;
   logic                  i_vblank;
   logic [1:0]            i_mode;
   logic [23:0]           i_fill;
   logic [23:0]           i_fg;
   logic [23:0]           i_bg;
   logic                  i_clr_count;
   logic [23:0]           o_rgb;
   logic                  o_valid;
   logic                  o_frame_err;
   logic [CNT_WIDTH-1:0]  o_underflow_count;

   modport master (
      output i_word, i_empty, i_pixel_ready, i_vblank, i_mode,
             i_fill, i_fg, i_bg, i_clr_count,
      input  o_rd_en, o_rgb, o_valid, o_frame_err, o_underflow_count
   );

   modport slave (
      input  i_word, i_empty, i_pixel_ready, i_vblank, i_mode,
             i_fill, i_fg, i_bg, i_clr_count,
      output o_rd_en, o_rgb, o_valid, o_frame_err, o_underflow_count
   );
endinterface

// File: rtl/pixel_unpacker.sv
// Unpacks FWFT FIFO words into 24-bit pixels (RGB888/RGB565/mono/fill), one-cycle latency,
// no backpressure: every request is answered, with the fill colour substituted on FIFO underflow.
module pixel_unpacker #(
   parameter int WORD_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   pixel_unpacker_if.slave   bus
);
   localparam int IDX_W = $clog2(WORD_WIDTH);

   typedef enum logic [1:0] {
      MODE_RGB888 = 2'd0,
      MODE_RGB565 = 2'd1,
      MODE_MONO   = 2'd2,
      MODE_FILL   = 2'd3
   } mode_t;

   logic             vblank_q;
   logic             armed_q;
   mode_t            mode_q;
   logic [IDX_W-1:0] idx_q;

   logic             frame_start;
   mode_t            mode_eff;
   logic [IDX_W-1:0] idx_eff;
   logic [IDX_W-1:0] idx_last;
   logic [IDX_W-1:0] idx_nxt;
   logic             discard;
   logic             pop;
   logic             underflow;
   logic [23:0]      pix;
   logic [23:0]      pix888;
   logic [23:0]      pix565;
   logic [23:0]      pixmono;
   logic [15:0]      half;

   // armed_q blocks a vblank that was already high when reset released from counting as an edge
   always_comb begin
      frame_start = bus.i_vblank & ~vblank_q & armed_q;
      mode_eff    = frame_start ? mode_t'(bus.i_mode) : mode_q;
      idx_eff     = frame_start ? '0 : idx_q;
      discard     = frame_start & (idx_q != '0) & ~bus.i_empty;

      case (mode_eff)
         MODE_RGB888: idx_last = IDX_W'(WORD_WIDTH / 32 - 1);
         MODE_RGB565: idx_last = IDX_W'(WORD_WIDTH / 16 - 1);
         MODE_MONO:   idx_last = IDX_W'(WORD_WIDTH - 1);
         default:     idx_last = '0;
      endcase

      pix888  = 24'(bus.i_word >> {idx_eff, 5'b0});
      half    = 16'(bus.i_word >> {idx_eff, 4'b0});
      pix565  = {half[15:11], half[15:13], half[10:5], half[10:9], half[4:0], half[4:2]};
      pixmono = bus.i_word[idx_eff] ? bus.i_fg : bus.i_bg;
   end

   // A request colliding with a partial-word discard has no valid head word, so it is an underflow
   always_comb begin
      pop       = 1'b0;
      underflow = 1'b0;
      pix       = bus.i_fill;
      idx_nxt   = idx_eff;
      if (bus.i_pixel_ready && mode_eff != MODE_FILL) begin
         if (discard || bus.i_empty) begin
            underflow = 1'b1;
         end else begin
            case (mode_eff)
               MODE_RGB888: pix = pix888;
               MODE_RGB565: pix = pix565;
               default:     pix = pixmono;
            endcase
            if (idx_eff == idx_last) begin
               pop     = 1'b1;
               idx_nxt = '0;
            end else begin
               idx_nxt = idx_eff + 1'b1;
            end
         end
      end
   end

   assign bus.o_rd_en = ~reset & (pop | discard);

   always_ff @(posedge clk) begin
      if (reset) begin
         vblank_q              <= 1'b0;
         armed_q               <= ~bus.i_vblank;
         mode_q                <= MODE_RGB888;
         idx_q                 <= '0;
         bus.o_rgb             <= '0;
         bus.o_valid           <= 1'b0;
         bus.o_frame_err       <= 1'b0;
         bus.o_underflow_count <= '0;
      end else begin
         vblank_q    <= bus.i_vblank;
         armed_q     <= armed_q | ~bus.i_vblank;
         idx_q       <= idx_nxt;
         bus.o_valid <= bus.i_pixel_ready;
         if (frame_start)
            mode_q <= mode_t'(bus.i_mode);
         if (bus.i_pixel_ready)
            bus.o_rgb <= pix;
         if (underflow)
            bus.o_frame_err <= 1'b1;
         else if (frame_start)
            bus.o_frame_err <= 1'b0;
         if (bus.i_clr_count)
            bus.o_underflow_count <= '0;
         else if (underflow && !(&bus.o_underflow_count))
            bus.o_underflow_count <= bus.o_underflow_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed self-checking bench for pixel_unpacker at WORD_WIDTH 32 and 64.
module tb_pixel_unpacker;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [23:0] exp64 [4];

   pixel_unpacker_if #(.WORD_WIDTH(32), .CNT_WIDTH(16)) b ();
   pixel_unpacker_if #(.WORD_WIDTH(64), .CNT_WIDTH(16)) w ();

   pixel_unpacker #(.WORD_WIDTH(32), .CNT_WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(b));
   pixel_unpacker #(.WORD_WIDTH(64), .CNT_WIDTH(16)) dut64 (.clk(clk), .reset(reset), .bus(w));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic vbl_pulse();
      b.i_pixel_ready = 1'b0;
      b.i_vblank = 1'b1;
      cycle();
      b.i_vblank = 1'b0;
      cycle();
   endtask

   initial begin
      exp64[0] = 24'h00FF00;
      exp64[1] = 24'h0000FF;
      exp64[2] = 24'hFF0000;
      exp64[3] = 24'h000000;

      reset = 1'b1;
      b.i_word = 32'hAA112233; b.i_empty = 1'b0; b.i_pixel_ready = 1'b1;
      b.i_vblank = 1'b0; b.i_mode = 2'd0; b.i_fill = 24'h123456;
      b.i_fg = 24'hFFFFFF; b.i_bg = 24'h000080; b.i_clr_count = 1'b0;
      w.i_word = '0; w.i_empty = 1'b1; w.i_pixel_ready = 1'b0;
      w.i_vblank = 1'b0; w.i_mode = 2'd0; w.i_fill = 24'h123456;
      w.i_fg = 24'hFFFFFF; w.i_bg = 24'h000080; w.i_clr_count = 1'b0;
      #2;
      chk("rst_rd_en", b.o_rd_en, 0);
      cycle();
      cycle();
      chk("rst_rgb", b.o_rgb, 0);
      chk("rst_valid", b.o_valid, 0);
      chk("rst_err", b.o_frame_err, 0);
      chk("rst_cnt", b.o_underflow_count, 0);

      // mode 0
      reset = 1'b0;
      b.i_mode = 2'd0;
      vbl_pulse();
      b.i_pixel_ready = 1'b1; b.i_word = 32'hAA112233; #1;
      chk("m0_rd0", b.o_rd_en, 1);
      cycle();
      chk("m0_rgb0", b.o_rgb, 24'h112233);
      chk("m0_vld0", b.o_valid, 1);
      b.i_word = 32'h00445566; #1;
      chk("m0_rd1", b.o_rd_en, 1);
      cycle();
      chk("m0_rgb1", b.o_rgb, 24'h445566);
      b.i_pixel_ready = 1'b0; b.i_empty = 1'b1;
      cycle();
      chk("m0_vld_idle", b.o_valid, 0);
      chk("m0_hold", b.o_rgb, 24'h445566);

      // mode 1
      b.i_mode = 2'd1;
      vbl_pulse();
      b.i_empty = 1'b0; b.i_word = 32'hF80007E0; b.i_pixel_ready = 1'b1; #1;
      chk("m1_rd0", b.o_rd_en, 0);
      cycle();
      chk("m1_rgb0", b.o_rgb, 24'h00FF00);
      chk("m1_rd1", b.o_rd_en, 1);
      cycle();
      chk("m1_rgb1", b.o_rgb, 24'hFF0000);

      // mode 2
      b.i_mode = 2'd2;
      vbl_pulse();
      b.i_word = 32'h00000005; b.i_pixel_ready = 1'b1;
      for (int k = 0; k < 32; k++) begin
         #1;
         chk($sformatf("m2_rd%0d", k), b.o_rd_en, (k == 31) ? 1 : 0);
         cycle();
         chk($sformatf("m2_rgb%0d", k), b.o_rgb, (k == 0 || k == 2) ? 24'hFFFFFF : 24'h000080);
      end

      // underflow
      b.i_empty = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("uf_rd%0d", k), b.o_rd_en, 0);
         cycle();
         chk($sformatf("uf_rgb%0d", k), b.o_rgb, 24'h123456);
      end
      chk("uf_cnt3", b.o_underflow_count, 3);
      chk("uf_err", b.o_frame_err, 1);
      b.i_pixel_ready = 1'b0; b.i_vblank = 1'b1;
      cycle();
      chk("uf_err_clr", b.o_frame_err, 0);
      chk("uf_cnt_keep", b.o_underflow_count, 3);
      b.i_vblank = 1'b0; b.i_pixel_ready = 1'b1; b.i_clr_count = 1'b1;
      cycle();
      chk("uf_clr_cnt", b.o_underflow_count, 0);
      chk("uf_clr_err", b.o_frame_err, 1);
      b.i_clr_count = 1'b0; b.i_pixel_ready = 1'b0;
      cycle();

      // mode switch mid-frame
      b.i_mode = 2'd1;
      vbl_pulse();
      b.i_empty = 1'b0; b.i_word = 32'hF80007E0; b.i_pixel_ready = 1'b1;
      cycle();
      chk("sw_rgb0", b.o_rgb, 24'h00FF00);
      b.i_pixel_ready = 1'b0; b.i_mode = 2'd0;
      cycle();
      cycle();
      b.i_vblank = 1'b1; #1;
      chk("sw_discard", b.o_rd_en, 1);
      cycle();
      b.i_vblank = 1'b0; b.i_word = 32'h00445566; b.i_pixel_ready = 1'b1; #1;
      chk("sw_rd", b.o_rd_en, 1);
      cycle();
      chk("sw_rgb_m0", b.o_rgb, 24'h445566);
      b.i_mode = 2'd2; b.i_word = 32'hAA112233;
      cycle();
      chk("sw_ignore", b.o_rgb, 24'h112233);

      // reset mid-word
      b.i_pixel_ready = 1'b0;
      vbl_pulse();
      b.i_word = 32'h00000005; b.i_pixel_ready = 1'b1;
      cycle();
      chk("rm_fg", b.o_rgb, 24'hFFFFFF);
      b.i_empty = 1'b1;
      cycle();
      chk("rm_uf_cnt", b.o_underflow_count, 1);
      reset = 1'b1; b.i_vblank = 1'b1; b.i_empty = 1'b0;
      b.i_word = 32'hAA112233; b.i_mode = 2'd1; #1;
      chk("rm_rd_en", b.o_rd_en, 0);
      cycle();
      chk("rm_rgb", b.o_rgb, 0);
      chk("rm_valid", b.o_valid, 0);
      chk("rm_err", b.o_frame_err, 0);
      chk("rm_cnt", b.o_underflow_count, 0);
      reset = 1'b0; #1;
      chk("rm_rd_m0", b.o_rd_en, 1);
      cycle();
      chk("rm_no_edge", b.o_rgb, 24'h112233);
      b.i_pixel_ready = 1'b0; b.i_vblank = 1'b0; b.i_mode = 2'd0;
      cycle();
      vbl_pulse();
      b.i_word = 32'h00445566; b.i_pixel_ready = 1'b1;
      cycle();
      chk("rm_m0_px0", b.o_rgb, 24'h445566);
      b.i_pixel_ready = 1'b0;

      // 64-bit word, RGB565: four pixels per pop
      w.i_mode = 2'd1; w.i_vblank = 1'b1;
      cycle();
      w.i_vblank = 1'b0;
      cycle();
      w.i_empty = 1'b0; w.i_word = 64'h0000_F800_001F_07E0; w.i_pixel_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("w64_rd%0d", k), w.o_rd_en, (k == 3) ? 1 : 0);
         cycle();
         chk($sformatf("w64_rgb%0d", k), w.o_rgb, exp64[k]);
      end
      w.i_pixel_ready = 1'b0;
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pixel_unpacker.md
# pixel_unpacker

Pixel-clock-domain scanout stage between the framebuffer async FIFO (first-word-fall-through read side) and the HDMI core's RGB input. It unpacks FIFO words of parametrised width into 24-bit pixels in one of several packing modes, substitutes a fill colour on FIFO underflow, and re-aligns to pixel 0 of a word at every frame start. It counts and flags underflows for software visibility.

## Interface

Parameters:
- WORD_WIDTH, 32, FIFO word width; legal values 32, 64, 128.
- CNT_WIDTH, 16, width of the underflow counter.

Ports:
- clk  in  1  pixel clock; the only clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- i_word  in  WORD_WIDTH  FIFO head word (FWFT).
- i_empty  in  1  FIFO empty.
- o_rd_en  out  1  FIFO pop, combinational.
- i_pixel_ready  in  1  HDMI core requests one active pixel this cycle.
- i_vblank  in  1  vertical blank from the HDMI core.
- i_mode  in  2  0=RGB888 (32 b/px), 1=RGB565 (16 b/px), 2=mono 1 b/px, 3=solid fill.
- i_fill  in  24  underflow / mode-3 colour.
- i_fg, i_bg  in  24 each  mono-mode colours for bit=1 / bit=0.
- i_clr_count  in  1  single-cycle pulse; clears the underflow counter.
- o_rgb  out  24  pixel {r,g,b}, registered.
- o_valid  out  1  o_rgb updated this cycle.
- o_frame_err  out  1  sticky: at least one underflow this frame.
- o_underflow_count  out  CNT_WIDTH  saturating underflow total.

## Operation

- Pixels per word: PPW = WORD_WIDTH/32 (mode 0), WORD_WIDTH/16 (mode 1), WORD_WIDTH (mode 2). Index register idx has width clog2(WORD_WIDTH). Pixel k is taken from the low end first.
- Mode 0: pixel k = i_word[32k+23:32k]; bits [32k+31:32k+24] are ignored.
- Mode 1: h = i_word[16k+15:16k]; r={h[15:11],h[15:13]}, g={h[10:5],h[10:9]}, b={h[4:0],h[4:2]}.
- Mode 2: bit i_word[k]; 1 → i_fg, 0 → i_bg.
- Mode 3: every requested pixel is i_fill. No FIFO reads and no underflow counting.
- Active mode is a register loaded from i_mode only at frame start. Mid-frame changes to i_mode have no effect.
- Frame start is the cycle in which i_vblank is high and its registered previous value is low. On frame start:
  - idx is set to 0, the mode is latched, and o_frame_err is cleared.
  - If idx≠0 and !i_empty, o_rd_en=1 to discard the partially consumed word.
- Pixel request, active mode 0–2, not frame start:
  - If !i_empty: output pixel idx. If idx==PPW-1, assert o_rd_en and set idx to 0; otherwise idx increments.
  - If i_empty (underflow): output i_fill, idx unchanged, o_rd_en=0, o_frame_err set, counter increments.
- Pixel request on a frame-start cycle: the frame-start actions apply, and the pixel is output from idx=0 using the newly latched mode.
- o_rd_en is gated by !reset and is never asserted while i_empty=1.
- Counter saturates at all-ones. i_clr_count wins over a simultaneous increment (result 0). o_frame_err is not affected by i_clr_count.

## Timing

- Latency is 1 cycle: a request at cycle n gives o_rgb/o_valid at n+1. o_rd_en is in the same cycle n as the request.
- o_valid is high exactly one cycle per request. o_rgb holds its value when o_valid=0.
- Back-to-back requests every cycle are supported at full rate, including consecutive pops in mode 0 with WORD_WIDTH=32.
- Reset values: o_rgb=0, o_valid=0, o_frame_err=0, o_underflow_count=0, idx=0, latched mode=0, vblank history=0.
  - Reset applied mid-frame takes effect on the next edge.
  - The first frame start after reset requires a vblank rising edge; a vblank already high at reset release does not count.
- Counter and o_frame_err update on the cycle after the underflowing request, in step with o_valid.

## Test plan

- WORD_WIDTH=32, mode 0, FIFO holds 0xAA112233 then 0x00445566; two requests → o_rgb 0x112233 then 0x445566 one cycle after each request; o_rd_en high on both requests.
- Mode 1, word 0xF80007E0, two requests → 0x00FF00 then 0xFF0000; o_rd_en only on the second. With WORD_WIDTH=64, one pop per 4 pixels.
- Mode 2, i_fg=0xFFFFFF, i_bg=0x000080, word 0x00000005 → fg, bg, fg, then 29 × bg; single pop on the 32nd request.
- Underflow: i_empty high for 3 requests → three i_fill outputs, count=3, o_frame_err=1, no pops. Vblank rising edge → o_frame_err=0, count stays 3. i_clr_count together with a 4th underflow → count=0.
- Mode 1 frame with 1 of 2 halves consumed, i_mode switched to 0 mid-frame → no change until vblank rising edge. At the edge the partial word is popped, mode 0 is active, and the next request outputs the following word's pixel 0.
- Reset asserted mid-word (idx=1, mode 2) → next cycle all outputs at reset values; o_rd_en=0 during reset; after release and a vblank edge, decoding starts at pixel 0 in mode 0.
